pwm_duty_ramp_ctrl: RTL and testbench



---
 rtl/pwm_pkg.sv | 15 +
 rtl/duty_step_unit.sv | 35 +++
 rtl/pwm_duty_ramp_ctrl.sv | 113 +++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp sequencer.
//   DUTY_W_DEF  : default width of duty, step and target values
//   DWELL_W_DEF : default width of the dwell (PWM periods per step) count
//   DUTY_MAX    : full-scale duty for the default width
//   state_e     : sequencer states
package pwm_pkg;
  localparam int DUTY_W_DEF  = 8;
  localparam int DWELL_W_DEF = 8;
  localparam int DUTY_MAX    = 2**DUTY_W_DEF - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;
endpackage

// File: rtl/duty_step_unit.sv
// Combinational saturating step of a duty value toward a target.
//   duty_i      : current duty
//   target_i    : duty being approached
//   step_i      : increment per step (0 behaves as 1)
//   next_duty_o : duty after one step, clamped so it never passes the target
//   at_target_o : next_duty_o equals target_i
module duty_step_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] duty_i,
  input  logic [W-1:0] target_i,
  input  logic [W-1:0] step_i,
  output logic [W-1:0] next_duty_o,
  output logic         at_target_o
);
  // One extra bit so the sum cannot wrap past full scale.
  logic [W:0] eff_step, duty_x, tgt_x, up, dn;

  always_comb begin
    eff_step    = (step_i == '0) ? (W+1)'(1) : {1'b0, step_i};
    duty_x      = {1'b0, duty_i};
    tgt_x       = {1'b0, target_i};
    up          = duty_x + eff_step;
    dn          = duty_x - eff_step;
    next_duty_o = duty_i;
    if (tgt_x > duty_x) begin
      next_duty_o = (up > tgt_x) ? target_i : up[W-1:0];
    end else if (tgt_x < duty_x) begin
      // A step larger than the duty would underflow; that case lands on target.
      if (duty_x < eff_step || dn < tgt_x) next_duty_o = target_i;
      else                                 next_duty_o = dn[W-1:0];
    end
    at_target_o = (next_duty_o == target_i);
  end
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Slews the PWM duty toward the SPI-programmed target by step_size once every
// dwell PWM periods, updating only on period boundaries. With ramp_en low the
// target passes straight through (one-cycle latency).
//   clk, rst_n   : clock, synchronous active-low reset
//   ramp_en      : 1 = ramp toward target, 0 = bypass
//   target_duty  : target duty from the register bank
//   step_size    : duty increment per step (0 behaves as 1)
//   dwell        : PWM periods per step (0 behaves as 1)
//   period_start : one-cycle pulse at PWM counter wrap
//   duty_out     : registered effective duty to the PWM peripheral
//   busy         : ramp in progress
//   done         : one-cycle pulse when a ramp lands on its target
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ramp_en,
  input  logic [DUTY_W-1:0]  target_duty,
  input  logic [DUTY_W-1:0]  step_size,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               period_start,
  output logic [DUTY_W-1:0]  duty_out,
  output logic               busy,
  output logic               done
);
  state_e             state_q, state_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [DUTY_W-1:0]  next_duty;
  logic               at_target;
  logic [DWELL_W-1:0] eff_dwell;
  logic [DWELL_W:0]   cnt_inc;
  logic               dwell_hit;

  duty_step_unit #(.W(DUTY_W)) u_step (
    .duty_i      (duty_q),
    .target_i    (target_duty),
    .step_i      (step_size),
    .next_duty_o (next_duty),
    .at_target_o (at_target)
  );

  assign eff_dwell = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign cnt_inc   = {1'b0, cnt_q} + (DWELL_W+1)'(1);
  // >= rather than == so a dwell lowered mid-ramp still releases a step.
  assign dwell_hit = (cnt_inc >= {1'b0, eff_dwell});

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ramp_en) begin
          duty_d = target_duty;
        end else if (duty_q != target_duty) begin
          state_d = RAMP;
          cnt_d   = '0;
        end
      end
      RAMP: begin
        if (!ramp_en) begin
          duty_d  = target_duty;
          state_d = IDLE;
        end else if (duty_q == target_duty) begin
          // Target moved onto the current duty: finish without a period edge.
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (period_start) begin
          if (dwell_hit) begin
            duty_d = next_duty;
            cnt_d  = '0;
            if (at_target) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc[DWELL_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RAMP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench: stimulus pushes each expected change of {duty, busy, done};
// a negedge monitor pops and compares whenever that tuple changes.
module tb_pwm_duty_ramp_ctrl;
  import pwm_pkg::*;

  typedef struct packed {
    logic [7:0] duty;
    logic       busy;
    logic       done;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n, ramp_en, period_start;
  logic [7:0] target_duty, step_size, dwell;
  logic [7:0] duty_out;
  logic       busy, done;

  int  compared   = 0;
  int  mismatched = 0;
  bit  mon_en     = 1'b0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  pwm_duty_ramp_ctrl #(.DUTY_W(8), .DWELL_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ramp_en      (ramp_en),
    .target_duty  (target_duty),
    .step_size    (step_size),
    .dwell        (dwell),
    .period_start (period_start),
    .duty_out     (duty_out),
    .busy         (busy),
    .done         (done)
  );

  // Monitor: every change of the output tuple is one observed response.
  ev_t last, cur, e;
  always @(negedge clk) begin
    if (!mon_en) begin
      last = '0;
    end else begin
      cur = '{duty: duty_out, busy: busy, done: done};
      if (cur != last) begin
        last = cur;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event got duty=%0d busy=%0b done=%0b at %0t",
                   cur.duty, cur.busy, cur.done, $time);
        end else begin
          e = exp_q.pop_front();
          if (e != cur) begin
            mismatched++;
            $display("FAIL event got duty=%0d busy=%0b done=%0b want duty=%0d busy=%0b done=%0b at %0t",
                     cur.duty, cur.busy, cur.done, e.duty, e.busy, e.done, $time);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic b, input logic dn);
    exp_q.push_back('{duty: d, busy: b, done: dn});
  endtask

  task automatic pulse(input int gap);
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    @(negedge clk);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending events want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Bypass to a known duty before a ramp test.
  task automatic set_duty(input logic [7:0] d);
    ramp_en = 1'b0; target_duty = d;
    push(d, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    // 1. Reset with busy inputs, then bypass.
    rst_n = 1'b0; ramp_en = 1'b1; target_duty = 8'h55;
    step_size = 8'd4; dwell = 8'd1; period_start = 1'b1;
    tick(); tick();
    chk("reset_duty", duty_out, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    rst_n = 1'b1; ramp_en = 1'b0; target_duty = 8'h80; period_start = 1'b0;
    mon_en = 1'b1;
    push(8'h80, 1'b0, 1'b0);
    tick(); tick();
    drain();

    // 2. 0 -> 100, step 10, dwell 2, period 256.
    set_duty(8'd0);
    ramp_en = 1'b1; target_duty = 8'd100; step_size = 8'd10; dwell = 8'd2;
    push(8'd0, 1'b1, 1'b0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (k % 2 == 0) begin
        if (k == 20) begin
          push(8'd100, 1'b0, 1'b1);
          push(8'd100, 1'b0, 1'b0);
        end else begin
          push(8'(k * 5), 1'b1, 1'b0);
        end
      end
      pulse(255);
    end
    drain();
    // Period pulses in IDLE with duty == target: no events.
    pulse(3); pulse(3);

    // 3. Saturation up and down.
    set_duty(8'd250);
    ramp_en = 1'b1; target_duty = 8'd255; step_size = 8'd16; dwell = 8'd1;
    push(8'd250, 1'b1, 1'b0);
    tick();
    push(8'd255, 1'b0, 1'b1);
    push(8'd255, 1'b0, 1'b0);
    pulse(4);
    set_duty(8'd5);
    ramp_en = 1'b1; target_duty = 8'd0; step_size = 8'd8;
    push(8'd5, 1'b1, 1'b0);
    tick();
    push(8'd0, 1'b0, 1'b1);
    push(8'd0, 1'b0, 1'b0);
    pulse(4);
    drain();

    // 4. Retarget mid-ramp: 0 -> 200 step 20, at 60 retarget to 30.
    ramp_en = 1'b1; target_duty = 8'd200; step_size = 8'd20; dwell = 8'd1;
    push(8'd0, 1'b1, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      push(8'(k * 20), 1'b1, 1'b0);
      pulse(3);
    end
    target_duty = 8'd30;
    push(8'd40, 1'b1, 1'b0);
    pulse(3);
    push(8'd30, 1'b0, 1'b1);
    push(8'd30, 1'b0, 1'b0);
    pulse(3);
    drain();

    // 5a. ramp_en drops at duty 40 -> target passes through, no done.
    set_duty(8'd0);
    ramp_en = 1'b1; target_duty = 8'd200; step_size = 8'd20;
    push(8'd0, 1'b1, 1'b0);
    tick();
    push(8'd20, 1'b1, 1'b0); pulse(3);
    push(8'd40, 1'b1, 1'b0); pulse(3);
    ramp_en = 1'b0;
    push(8'd200, 1'b0, 1'b0);
    tick(); tick(); tick();
    drain();

    // 5b. step=0 and dwell=0 behave as 1: 0 -> 3 in three consecutive pulses.
    set_duty(8'd0);
    ramp_en = 1'b1; target_duty = 8'd3; step_size = 8'd0; dwell = 8'd0;
    push(8'd0, 1'b1, 1'b0);
    tick();
    push(8'd1, 1'b1, 1'b0); pulse(0);
    push(8'd2, 1'b1, 1'b0); pulse(0);
    push(8'd3, 1'b0, 1'b1);
    push(8'd3, 1'b0, 1'b0);
    pulse(3);
    drain();

    // 5c. Target moved onto the current duty: done without a period pulse.
    set_duty(8'd0);
    ramp_en = 1'b1; target_duty = 8'd100; step_size = 8'd10; dwell = 8'd1;
    push(8'd0, 1'b1, 1'b0);
    tick();
    push(8'd10, 1'b1, 1'b0); pulse(3);
    target_duty = 8'd10;
    push(8'd10, 1'b0, 1'b1);
    push(8'd10, 1'b0, 1'b0);
    tick(); tick(); tick();
    drain();

    // 6. Reset mid-ramp at duty 70.
    set_duty(8'd0);
    ramp_en = 1'b1; target_duty = 8'd200; step_size = 8'd70; dwell = 8'd1;
    push(8'd0, 1'b1, 1'b0);
    tick();
    push(8'd70, 1'b1, 1'b0); pulse(3);
    drain();
    mon_en = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midreset_duty", duty_out, 8'd0);
    chk("midreset_busy", {7'd0, busy}, 8'd0);
    chk("midreset_done", {7'd0, done}, 8'd0);
    ramp_en = 1'b0; target_duty = 8'd0; rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    tick(); tick(); tick();
    chk("post_reset_done", {7'd0, done}, 8'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
